hall_call_dispatcher: RTL and testbench

// - Upstream feeder for the lift controller: turns raw per-floor hall-call buttons into a serialized
//   4-bit floor request stream (4'hF = no request) on the lift's floorReq input.
// - Debounces buttons, lights hall lamps, queues calls in arrival order, issues one request at a time,

---
 rtl/hall_call_dispatcher_if.sv | 33 +++
 rtl/hall_call_dispatcher.sv | 215 +++++++++++++++++++++
 tb/tb_hall_call_dispatcher.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hall_call_dispatcher_if.sv
// Bundles the hall-call dispatcher's functional signals.
// Signal summary:
//   hall_btn      raw hall buttons, bit f = floor f
//   lift_floor    current lift floor
//   motor_signal  lift motor state: 00 idle, 11 up, 10 down
//   floor_req     request to the lift: a floor index for one cycle, else 4'hF
//   hall_lamp     one call-registered lamp per floor
//   queue_cnt     calls queued but not yet issued
//   timeout_alarm sticky alarm: an issued call was not serviced in time
// Modports:
//   master  drives the buttons and the lift feedback (the environment side)
//   slave   the dispatcher itself
interface hall_call_dispatcher_if #(
    parameter int NUM_FLOORS = 11
);
    logic [NUM_FLOORS-1:0] hall_btn;
    logic [3:0]            lift_floor;
    logic [1:0]            motor_signal;
    logic [3:0]            floor_req;
    logic [NUM_FLOORS-1:0] hall_lamp;
    logic [3:0]            queue_cnt;
    logic                  timeout_alarm;

    modport master (
        output hall_btn, lift_floor, motor_signal,
        input  floor_req, hall_lamp, queue_cnt, timeout_alarm
    );

    modport slave (
        input  hall_btn, lift_floor, motor_signal,
        output floor_req, hall_lamp, queue_cnt, timeout_alarm
    );
endinterface

// File: rtl/hall_call_dispatcher.sv
// Hall-call dispatcher.
// It debounces the per-floor hall buttons and lights a lamp for each accepted
// call. Calls are queued in arrival order and issued to the lift one at a time
// as single-cycle floor requests, with idle cycles forced between requests.
// A lamp is cleared when the lift reaches a floor whose call has been issued.
// Ports:
//   clk  clock; all logic uses the rising edge
//   rst  asynchronous, active-high reset; drops every pending call
//   bus  hall_call_dispatcher_if.slave: buttons, lift feedback, request, lamps,
//        queue count and alarm
// Optional feature:
//   HALL_CALL_TIMEOUT_EN  When defined, each issued call has a service timer.
//                         If the lift does not reach the floor within
//                         TIMEOUT_CYCLES, the call is re-queued and
//                         timeout_alarm latches until reset. When undefined,
//                         timeout_alarm is tied to 0.
module hall_call_dispatcher #(
    parameter int NUM_FLOORS      = 11,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 2,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    hall_call_dispatcher_if.slave bus
);
    localparam int              PW       = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
    localparam logic [4:0]      DB_HIT   = 5'(DEBOUNCE_CYCLES);
    localparam logic [4:0]      DB_SAT   = 5'(DEBOUNCE_CYCLES + 1);
    localparam logic [3:0]      NO_REQ   = 4'hF;
    localparam logic [PW-1:0]   PTR_LAST = PW'(NUM_FLOORS - 1);
    // The IDLE cycle that pops the next call already shows 4'hF, so the GAP
    // state only has to add the remaining GAP_CYCLES-1 idle cycles.
    localparam logic [3:0]      GAP_LAST = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t                state_q;
    logic [3:0]            req_q;
    logic [3:0]            gap_cnt_q;
    logic [4:0]            db_cnt_q [NUM_FLOORS];
    logic [4:0]            db_cnt_d [NUM_FLOORS];
    logic [3:0]            fifo_q   [NUM_FLOORS];
    logic [3:0]            fifo_d   [NUM_FLOORS];
    logic [NUM_FLOORS-1:0] lamp_q, lamp_d;
    logic [NUM_FLOORS-1:0] unq_q, unq_d;
    logic [NUM_FLOORS-1:0] issued_q, issued_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]            count_q, count_d;
    logic [NUM_FLOORS-1:0] clr_s, acc_s, set_s, to_s, push_oh_s;
    logic                  push_s, pop_s;
    logic [3:0]            push_idx_s;

    assign pop_s = (state_q == S_IDLE) && (count_q != 4'd0);

    // Debounce counters, lamp-clear detection, press acceptance and issue marking.
    always_comb begin
        for (int f = 0; f < NUM_FLOORS; f++) begin
            // The counter saturates one above the threshold, so the event
            // fires exactly once per press and needs a 0 sample to re-arm.
            db_cnt_d[f] = bus.hall_btn[f]
                        ? ((db_cnt_q[f] == DB_SAT) ? DB_SAT : db_cnt_q[f] + 5'd1)
                        : 5'd0;
            clr_s[f]    = issued_q[f] && (bus.lift_floor == 4'(f));
            // A clear on the same floor wins; a lift standing at the floor swallows the press.
            acc_s[f]    = (db_cnt_q[f] == DB_HIT) && !lamp_q[f] && !clr_s[f]
                        && !((bus.lift_floor == 4'(f)) && (bus.motor_signal == 2'b00));
            set_s[f]    = (state_q == S_ISSUE) && (req_q == 4'(f));
        end
    end

    // Enqueue selection: the lowest-index floor waiting to enter the FIFO goes first.
    always_comb begin
        push_s     = |unq_q;
        push_idx_s = 4'd0;
        push_oh_s  = '0;
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            push_idx_s = unq_q[f] ? 4'(f) : push_idx_s;
        end
        for (int f = 0; f < NUM_FLOORS; f++) begin
            push_oh_s[f] = push_s && (push_idx_s == 4'(f));
        end
    end

    // Next state of lamps, per-floor flags and the call FIFO.
    always_comb begin
        lamp_d   = (lamp_q & ~clr_s) | acc_s;
        issued_d = (issued_q & ~clr_s & ~to_s) | set_s;
        unq_d    = (unq_q | acc_s | to_s) & ~push_oh_s;
        fifo_d   = fifo_q;
        if (push_s) begin
            fifo_d[wr_ptr_q] = push_idx_s;
            wr_ptr_d         = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < NUM_FLOORS; f++) begin
                db_cnt_q[f] <= 5'd0;
                fifo_q[f]   <= 4'd0;
            end
            lamp_q   <= '0;
            unq_q    <= '0;
            issued_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 4'd0;
        end else begin
            db_cnt_q <= db_cnt_d;
            fifo_q   <= fifo_d;
            lamp_q   <= lamp_d;
            unq_q    <= unq_d;
            issued_q <= issued_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Issue FSM: pop one call, drive it for a single cycle, then hold off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            req_q     <= NO_REQ;
            gap_cnt_q <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop_s) begin
                        state_q <= S_ISSUE;
                        req_q   <= fifo_q[rd_ptr_q];
                    end else begin
                        state_q <= S_IDLE;
                        req_q   <= NO_REQ;
                    end
                end
                S_ISSUE: begin
                    req_q     <= NO_REQ;
                    gap_cnt_q <= 4'd1;
                    state_q   <= (GAP_CYCLES <= 1) ? S_IDLE : S_GAP;
                end
                S_GAP: begin
                    req_q <= NO_REQ;
                    if (gap_cnt_q >= GAP_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= NO_REQ;
                end
            endcase
        end
    end

`ifdef HALL_CALL_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q [NUM_FLOORS];
    logic [TW-1:0] timer_d [NUM_FLOORS];
    logic          alarm_q, alarm_d;

    // Service timers: restart on every issue, expire TIMEOUT_CYCLES edges later.
    always_comb begin
        for (int f = 0; f < NUM_FLOORS; f++) begin
            timer_d[f] = set_s[f] ? '0 : (issued_q[f] ? timer_q[f] + TW'(1) : '0);
            to_s[f]    = issued_q[f] && !clr_s[f] && (timer_q[f] == TO_LAST);
        end
        alarm_d = alarm_q | (|to_s);
    end

    // Timer and sticky alarm registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < NUM_FLOORS; f++) begin
                timer_q[f] <= '0;
            end
            alarm_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            alarm_q <= alarm_d;
        end
    end

    assign bus.timeout_alarm = alarm_q;
`else
    assign to_s              = '0;
    assign bus.timeout_alarm = 1'b0;
`endif

    assign bus.floor_req = req_q;
    assign bus.hall_lamp = lamp_q;
    assign bus.queue_cnt = count_q;
endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Testbench for hall_call_dispatcher. The bench compares the design against a
// call-level reference model on every cycle. It also applies a table of
// directed vectors, a set of hand-written multi-cycle sequences, and a
// randomized soak.
module tb_hall_call_dispatcher;
    localparam int NF    = 11;
    localparam int DB    = 4;
    localparam int GP    = 2;
    localparam int TO    = 16;
    localparam int NOREQ = 15;
    localparam int GAP_SPAN = (GP > 1) ? GP : 1;

    typedef struct {
        logic [NF-1:0] btn;
        logic [3:0]    lf;
        logic [1:0]    ms;
        logic [3:0]    req;
        logic [NF-1:0] lamp;
        logic [3:0]    cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    hall_call_dispatcher_if #(.NUM_FLOORS(NF)) bus_if ();

    hall_call_dispatcher #(
        .NUM_FLOORS(NF), .DEBOUNCE_CYCLES(DB), .GAP_CYCLES(GP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state, kept at the level of calls and time stamps.
    int            run [NF];
    int            age [NF];
    logic [NF-1:0] m_lamp, m_issued, m_unq;
    int            m_fifo[$];
    int            m_req;
    int            now;
    int            last_issue;
    logic          m_alarm;

    vec_t          tbl[$];
    int            reqs[$];
    int            whens[$];
    int            exp_f[3] = '{2, 7, 9};
    int            cnt_f;
    logic [NF-1:0] rb;
    int            rlf, rms;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int f = 0; f < NF; f++) begin
            run[f] = 0;
            age[f] = 0;
        end
        m_lamp = '0; m_issued = '0; m_unq = '0;
        m_fifo.delete();
        m_req = NOREQ; now = 0; last_issue = -100; m_alarm = 1'b0;
    endtask

    // One clock edge of the model: inputs are the values sampled at that edge.
    task automatic model_step(input logic [NF-1:0] btn, input int lf, input int ms);
        logic [NF-1:0] clr, acc, tmo, setb, pushb;
        int            pop_f;
        bit            pop;
        clr = '0; acc = '0; tmo = '0; setb = '0; pushb = '0; pop = 1'b0; pop_f = NOREQ;
        now++;
        for (int f = 0; f < NF; f++) begin
            clr[f] = m_issued[f] && (lf == f);
            acc[f] = (run[f] == DB) && !m_lamp[f] && !((lf == f) && (ms == 0)) && !clr[f];
`ifdef HALL_CALL_TIMEOUT_EN
            tmo[f] = m_issued[f] && !clr[f] && (age[f] == TO - 1);
`endif
        end
        if (m_fifo.size() > 0 && now >= last_issue + GAP_SPAN + 1) begin
            pop = 1'b1;
            pop_f = m_fifo.pop_front();
            last_issue = now;
        end
        for (int f = 0; f < NF; f++) begin
            if (m_unq[f]) begin
                pushb[f] = 1'b1;
                m_fifo.push_back(f);
                break;
            end
        end
        if (m_req != NOREQ) setb[m_req] = 1'b1;
        for (int f = 0; f < NF; f++) age[f] = setb[f] ? 0 : age[f] + 1;
        m_issued = (m_issued & ~clr & ~tmo) | setb;
        m_unq    = (m_unq | acc | tmo) & ~pushb;
        m_lamp   = (m_lamp & ~clr) | acc;
        m_alarm  = m_alarm | (|tmo);
        m_req    = pop ? pop_f : NOREQ;
        for (int f = 0; f < NF; f++) run[f] = btn[f] ? run[f] + 1 : 0;
    endtask

    task automatic cycle(input logic [NF-1:0] btn, input int lf, input int ms);
        bus_if.hall_btn     = btn;
        bus_if.lift_floor   = 4'(lf);
        bus_if.motor_signal = 2'(ms);
        @(posedge clk);
        model_step(btn, lf, ms);
        #1;
        chk("model_req",   bus_if.floor_req,     m_req);
        chk("model_lamp",  bus_if.hall_lamp,     m_lamp);
        chk("model_qcnt",  bus_if.queue_cnt,     m_fifo.size());
        chk("model_alarm", bus_if.timeout_alarm, m_alarm);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req",   bus_if.floor_req,     32'hF);
        chk("rst_lamp",  bus_if.hall_lamp,     32'h0);
        chk("rst_qcnt",  bus_if.queue_cnt,     32'h0);
        chk("rst_alarm", bus_if.timeout_alarm, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic add_vec(input logic [NF-1:0] b, input int lf, input int ms,
                           input int req, input logic [NF-1:0] lamp, input int cnt);
        vec_t v;
        v.btn = b; v.lf = 4'(lf); v.ms = 2'(ms);
        v.req = 4'(req); v.lamp = lamp; v.cnt = 4'(cnt);
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b0;
        bus_if.hall_btn = '0; bus_if.lift_floor = 4'd0; bus_if.motor_signal = 2'd0;

        // Floor 5 held for 10 cycles, lift at 0: lamp at edge 5, queued at 6, issued at 7.
        for (int i = 0; i < 4; i++) add_vec(11'h020, 0, 0, NOREQ, 11'h000, 0);
        add_vec(11'h020, 0, 0, NOREQ, 11'h020, 0);
        add_vec(11'h020, 0, 0, NOREQ, 11'h020, 1);
        add_vec(11'h020, 0, 0, 5,     11'h020, 0);
        for (int i = 0; i < 3; i++) add_vec(11'h020, 0, 0, NOREQ, 11'h020, 0);
        // Lift passes floor 5 moving up: lamp clears.
        add_vec(11'h000, 5, 3, NOREQ, 11'h000, 0);
        // Floor 3 glitch of 3 cycles: rejected.
        for (int i = 0; i < 3; i++) add_vec(11'h008, 5, 3, NOREQ, 11'h000, 0);
        for (int i = 0; i < 3; i++) add_vec(11'h000, 5, 3, NOREQ, 11'h000, 0);
        // Lift standing at floor 4: the press is swallowed.
        for (int i = 0; i < 6; i++) add_vec(11'h010, 4, 0, NOREQ, 11'h000, 0);
        add_vec(11'h000, 4, 0, NOREQ, 11'h000, 0);

        #2;
        do_reset();

        foreach (tbl[i]) begin
            cycle(tbl[i].btn, tbl[i].lf, tbl[i].ms);
            chk("tbl_req",  bus_if.floor_req, tbl[i].req);
            chk("tbl_lamp", bus_if.hall_lamp, tbl[i].lamp);
            chk("tbl_qcnt", bus_if.queue_cnt, tbl[i].cnt);
        end

        // Floors 2, 7 and 9 accepted together: issued in order, 3 cycles apart.
        for (int i = 0; i < 18; i++) begin
            cycle((i < 6) ? 11'h284 : 11'h000, 0, 0);
            if (bus_if.floor_req != 4'hF) begin
                reqs.push_back(int'(bus_if.floor_req));
                whens.push_back(i);
            end
        end
        chk("seqA_count", reqs.size(), 3);
        for (int k = 0; k < 3; k++) chk("seqA_order", (k < reqs.size()) ? reqs[k] : 99, exp_f[k]);
        if (whens.size() >= 3) begin
            chk("seqA_gap1", whens[1] - whens[0], 3);
            chk("seqA_gap2", whens[2] - whens[1], 3);
        end

        // Lift moves 6 -> 7 going up: lamp 7 clears, then a re-press relights it.
        cycle(11'h000, 6, 3);
        chk("seqB_lamp_pre", bus_if.hall_lamp, 11'h284);
        cycle(11'h000, 7, 3);
        chk("seqB_lamp7_clear", bus_if.hall_lamp, 11'h204);
        for (int i = 0; i < 6; i++) cycle(11'h080, 0, 3);
        chk("seqB_relight", bus_if.hall_lamp[7], 1);
        cnt_f = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(11'h000, 0, 3);
            if (bus_if.floor_req == 4'd7) cnt_f++;
        end
        chk("seqB_reissue7", cnt_f, 1);

        // Floor 4 pressed twice while lit: exactly one request.
        do_reset();
        cnt_f = 0;
        for (int i = 0; i < 19; i++) begin
            cycle((i < 5 || (i >= 8 && i < 13)) ? 11'h010 : 11'h000, 0, 0);
            if (bus_if.floor_req == 4'd4) cnt_f++;
        end
        chk("seqC_one_req", cnt_f, 1);
        chk("seqC_lamp", bus_if.hall_lamp, 11'h010);

`ifdef HALL_CALL_TIMEOUT_EN
        // Floor 8 issued, lift never arrives: reissue and sticky alarm.
        do_reset();
        cnt_f = 0;
        for (int i = 0; i < 60; i++) begin
            cycle((i < 6) ? 11'h100 : 11'h000, 0, 3);
            if (bus_if.floor_req == 4'd8) cnt_f++;
        end
        chk("to_reissue", (cnt_f >= 2) ? 1 : 0, 1);
        chk("to_alarm", bus_if.timeout_alarm, 1);
`endif

        // Randomized soak including out-of-range lift floors and one mid-run reset.
        do_reset();
        rb = '0; rlf = 0; rms = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int f = 0; f < NF; f++) begin
                if ($urandom_range(0, 5) == 0) rb[f] = ~rb[f];
            end
            if ($urandom_range(0, 7) == 0) begin
                rlf = $urandom_range(0, 15);
                case ($urandom_range(0, 2))
                    0:       rms = 0;
                    1:       rms = 3;
                    default: rms = 2;
                endcase
            end
            if (i == 700) do_reset();
            cycle(rb, rlf, rms);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
